// File: rtl/pic16_pkg.sv
// Shared PIC16 core definitions: OPTION register layout, reset values and SFR addresses.
package pic16_pkg;

  localparam int OPT_NRBPU  = 7;
  localparam int OPT_INTEDG = 6;
  localparam int OPT_T0CS   = 5;
  localparam int OPT_T0SE   = 4;
  localparam int OPT_PSA    = 3;
  localparam int OPT_PS_MSB = 2;

  localparam logic [7:0] OPTION_RST = 8'hFF;
  localparam logic [7:0] TMR0_RST   = 8'h00;

  // Bit 8 (bank select) is a don't-care for both registers; compare with sfr_hit().
  localparam logic [8:0] SFR_TMR0   = 9'b0_0000_0001;
  localparam logic [8:0] SFR_OPTION = 9'b0_1000_0001;

  typedef struct packed {
    logic       nrbpu;
    logic       intedg;
    logic       t0cs;
    logic       t0se;
    logic       psa;
    logic [2:0] ps;
  } option_t;

  typedef enum logic {
    SRC_INTERNAL = 1'b0,
    SRC_EXTERNAL = 1'b1
  } tmr0_src_e;

  function automatic logic sfr_hit(input logic [8:0] addr, input logic [8:0] sfr);
    return addr[7:0] == sfr[7:0];
  endfunction

  // Low PS+1 bits set: the prescaler completes a period when those bits are all ones.
  function automatic logic [7:0] presc_mask(input logic [2:0] ps);
    return 8'hFF >> (3'd7 - ps);
  endfunction

endpackage

// File: rtl/pic16tmr0_presc.sv
// TMR0 prescaler: 8-bit tick counter, 1:2..1:256 ratio decode, PSA bypass and clear.
module pic16tmr0_presc
  import pic16_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       tick,
  input  logic       psa,
  input  logic [2:0] ps,
  output logic       inc
);

  logic [7:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
    end else if (tick && !psa) begin
      cnt_reg <= cnt_reg + 8'd1;
    end
  end

  // The tick that completes the count produces the increment in the same cycle.
  assign inc = tick && (psa || ((cnt_reg | ~presc_mask(ps)) == 8'hFF));

endmodule

// File: rtl/pic16tmr0.sv
// PIC16 Timer0: 8-bit counter with prescaler, OPTION register and overflow flag.
// Define TMR0_EXTCLK_EN to enable counting on synchronised T0CKI edges.
module pic16tmr0
  import pic16_pkg::*;
#(
  parameter int SYNC_STAGES = 2
)
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       T0CKI,
  input  logic       SLEEP,
  input  logic [7:0] WDATA,
  input  logic       TMR0_W,
  input  logic       OPT_W,
  input  logic       T0IF_C,
  output logic [7:0] TMR0,
  output logic [7:0] OPTION,
  output logic       T0IF
);

  option_t    option_reg;
  logic [7:0] tmr0_reg;
  logic       t0if_reg;
  logic [1:0] inhib_reg;
  logic       ext_edge;
  tmr0_src_e  src_sel;
  logic       src_tick;
  logic       tick;
  logic       inc;

`ifdef TMR0_EXTCLK_EN
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   last_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_reg <= '0;
      last_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], T0CKI};
      last_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  // Edge flop tracks the pin during SLEEP too, so no stale edge survives a wake-up.
  assign ext_edge = option_reg.t0se ? (last_reg & ~sync_reg[SYNC_STAGES-1])
                                    : (~last_reg & sync_reg[SYNC_STAGES-1]);
  assign src_sel  = option_reg.t0cs ? SRC_EXTERNAL : SRC_INTERNAL;
`else
  localparam int unused_sync_stages = SYNC_STAGES;
  logic unused_t0cki;
  assign unused_t0cki = T0CKI;
  assign ext_edge     = 1'b0;
  assign src_sel      = SRC_INTERNAL;
`endif

  assign src_tick = (src_sel == SRC_EXTERNAL) ? ext_edge : 1'b1;
  assign tick     = src_tick && !SLEEP && (inhib_reg == 2'd0);

  pic16tmr0_presc u_presc (
    .clk  (CLK),
    .rst  (RST),
    .clr  (TMR0_W || OPT_W),
    .tick (tick),
    .psa  (option_reg.psa),
    .ps   (option_reg.ps),
    .inc  (inc)
  );

  // After a TMR0 write the next two edges never increment.
  always_ff @(posedge CLK) begin
    if (RST) begin
      inhib_reg <= 2'd0;
    end else if (TMR0_W) begin
      inhib_reg <= 2'd2;
    end else if (inhib_reg != 2'd0) begin
      inhib_reg <= inhib_reg - 2'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tmr0_reg   <= TMR0_RST;
      option_reg <= option_t'(OPTION_RST);
      t0if_reg   <= 1'b0;
    end else begin
      if (OPT_W) begin
        option_reg <= option_t'(WDATA);
      end
      if (TMR0_W) begin
        tmr0_reg <= WDATA;
      end else if (inc) begin
        tmr0_reg <= tmr0_reg + 8'd1;
      end
      if (inc && !TMR0_W && (tmr0_reg == 8'hFF)) begin
        t0if_reg <= 1'b1;
      end else if (T0IF_C) begin
        t0if_reg <= 1'b0;
      end
    end
  end

  assign TMR0   = tmr0_reg;
  assign OPTION = option_reg;
  assign T0IF   = t0if_reg;

endmodule

// File: tb/tb_pic16tmr0.sv
// Self-checking bench for pic16tmr0: directed scenarios plus randomized traffic against a reference model.
module tb_pic16tmr0;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst, t0cki, sleep, tmr0_w, opt_w, t0if_c;
  logic [7:0] wdata;
  logic [7:0] tmr0, option;
  logic       t0if;

  pic16tmr0 #(.SYNC_STAGES(SYNC)) dut (
    .CLK    (clk),
    .RST    (rst),
    .T0CKI  (t0cki),
    .SLEEP  (sleep),
    .WDATA  (wdata),
    .TMR0_W (tmr0_w),
    .OPT_W  (opt_w),
    .T0IF_C (t0if_c),
    .TMR0   (tmr0),
    .OPTION (option),
    .T0IF   (t0if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: counter value, option byte, flag, ticks since prescaler clear,
  // remaining inhibited edges, and the history of pin values sampled at each edge.
  int         m_tmr0;
  logic [7:0] m_option;
  bit         m_t0if;
  int         m_pc;
  int         m_inh;
  bit         hist[$];

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int ratio;
    bit cs, older, newer, ext_edge, src, do_tick, do_inc, ovf;
    if (rst) begin
      m_tmr0 = 0; m_option = 8'hFF; m_t0if = 0; m_pc = 0; m_inh = 0;
      hist.delete();
      for (int i = 0; i <= SYNC; i++) hist.push_back(1'b0);
      return;
    end
`ifdef TMR0_EXTCLK_EN
    cs = m_option[5];
`else
    cs = 1'b0;
`endif
    // A pin edge counts SYNC+1 edges after the edge that first sampled it.
    older    = hist[hist.size() - 1 - SYNC];
    newer    = hist[hist.size() - SYNC];
    ext_edge = m_option[4] ? (older && !newer) : (!older && newer);
    src      = cs ? ext_edge : 1'b1;
    do_tick  = src && !sleep && (m_inh == 0);
    ratio    = m_option[3] ? 1 : (2 << m_option[2:0]);
    do_inc   = 0;
    ovf      = 0;
    if (do_tick) begin
      m_pc++;
      if (m_pc >= ratio) begin
        do_inc = 1;
        m_pc   = 0;
      end
    end
    if (tmr0_w || opt_w) m_pc = 0;
    if (m_inh > 0) m_inh--;
    if (tmr0_w) m_inh = 2;
    if (tmr0_w) m_tmr0 = wdata;
    else if (do_inc) begin
      if (m_tmr0 == 255) ovf = 1;
      m_tmr0 = (m_tmr0 + 1) % 256;
    end
    if (ovf) m_t0if = 1;
    else if (t0if_c) m_t0if = 0;
    if (opt_w) m_option = wdata;
    hist.push_back(t0cki);
    if (hist.size() > 8) void'(hist.pop_front());
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("tmr0_model", tmr0, 8'(m_tmr0));
    check("option_model", option, m_option);
    check("t0if_model", {7'd0, t0if}, {7'd0, m_t0if});
  endtask

  task automatic wr_opt(input logic [7:0] v);
    opt_w = 1'b1; wdata = v;
    cycle();
    opt_w = 1'b0;
    $display("write OPTION %02h -> TMR0 %02h OPTION %02h T0IF %0b", v, tmr0, option, t0if);
  endtask

  task automatic wr_tmr0(input logic [7:0] v);
    tmr0_w = 1'b1; wdata = v;
    cycle();
    tmr0_w = 1'b0;
    $display("write TMR0 %02h -> TMR0 %02h OPTION %02h T0IF %0b", v, tmr0, option, t0if);
  endtask

  initial begin
    logic [7:0] seq031 [5];
    logic [7:0] base;
    seq031 = '{8'hFD, 8'hFD, 8'hFE, 8'hFF, 8'h00};

    rst = 1'b1; t0cki = 1'b0; sleep = 1'b0; tmr0_w = 1'b0; opt_w = 1'b0; t0if_c = 1'b0; wdata = 8'h00;
    cycle();
    cycle();
    check("reset_tmr0", tmr0, 8'h00);
    check("reset_option", option, 8'hFF);
    check("reset_t0if", {7'd0, t0if}, 8'h00);
    rst = 1'b0;

    // Internal clock, no prescale: load, two held edges, then count through overflow.
    wr_opt(8'h08);
    wr_tmr0(8'hFD);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("seq031_tmr0", tmr0, seq031[i]);
      check("seq031_t0if", {7'd0, t0if}, (i == 4) ? 8'h01 : 8'h00);
    end
    t0if_c = 1'b1;
    cycle();
    t0if_c = 1'b0;
    check("t0if_clear", {7'd0, t0if}, 8'h00);

    // Clear strobe coinciding with overflow loses; alone it clears.
    wr_tmr0(8'hFF);
    cycle();
    cycle();
    t0if_c = 1'b1;
    cycle();
    check("ovf_clr_tmr0", tmr0, 8'h00);
    check("ovf_clr_t0if", {7'd0, t0if}, 8'h01);
    cycle();
    t0if_c = 1'b0;
    check("clr_alone_t0if", {7'd0, t0if}, 8'h00);
    $display("overflow/clear race done: TMR0 %02h T0IF %0b", tmr0, t0if);

    // 1:8 prescale, write mid-count restarts the period after the inhibit.
    wr_opt(8'h02);
    repeat (3) cycle();
    wr_tmr0(8'h40);
    for (int i = 0; i < 9; i++) begin
      cycle();
      check("presc8_hold", tmr0, 8'h40);
    end
    cycle();
    check("presc8_first", tmr0, 8'h41);
    repeat (7) cycle();
    check("presc8_hold2", tmr0, 8'h41);
    cycle();
    check("presc8_second", tmr0, 8'h42);
    $display("prescale 1:8 done: TMR0 %02h", tmr0);

    // SLEEP freezes the counter; counting resumes at once on wake.
    wr_opt(8'h08);
    wr_tmr0(8'h10);
    sleep = 1'b1;
    repeat (20) cycle();
    check("sleep_hold", tmr0, 8'h10);
    sleep = 1'b0;
    cycle();
    check("wake_1", tmr0, 8'h11);
    cycle();
    check("wake_2", tmr0, 8'h12);
    $display("sleep/wake done: TMR0 %02h", tmr0);

    // Reset overrides coincident writes, with T0IF set beforehand.
    wr_tmr0(8'hFE);
    repeat (4) cycle();
    check("pre_rst_t0if", {7'd0, t0if}, 8'h01);
    rst = 1'b1; tmr0_w = 1'b1; opt_w = 1'b1; wdata = 8'h55;
    cycle();
    rst = 1'b0; tmr0_w = 1'b0; opt_w = 1'b0;
    check("rst_win_tmr0", tmr0, 8'h00);
    check("rst_win_option", option, 8'hFF);
    check("rst_win_t0if", {7'd0, t0if}, 8'h00);
    $display("reset priority done: TMR0 %02h OPTION %02h T0IF %0b", tmr0, option, t0if);

    // Coincident TMR0 and OPTION writes both take effect.
    tmr0_w = 1'b1; opt_w = 1'b1; wdata = 8'h0A;
    cycle();
    tmr0_w = 1'b0; opt_w = 1'b0;
    check("both_w_tmr0", tmr0, 8'h0A);
    check("both_w_option", option, 8'h0A);

`ifdef TMR0_EXTCLK_EN
    // External clock, falling edge: each pulse counts on the third edge after the pin falls.
    wr_opt(8'h38);
    repeat (3) cycle();
    base = tmr0;
    for (int k = 0; k < 5; k++) begin
      t0cki = 1'b1;
      repeat (4) cycle();
      check("ext_fall_rise_ignored", tmr0, base + 8'(k));
      t0cki = 1'b0;
      repeat (2) cycle();
      check("ext_fall_early", tmr0, base + 8'(k));
      cycle();
      check("ext_fall_count", tmr0, base + 8'(k + 1));
      repeat (2) cycle();
      $display("T0CKI falling pulse %0d -> TMR0 %02h", k, tmr0);
    end
    wr_opt(8'h28);
    repeat (3) cycle();
    base = tmr0;
    for (int k = 0; k < 3; k++) begin
      t0cki = 1'b1;
      repeat (2) cycle();
      check("ext_rise_early", tmr0, base + 8'(k));
      cycle();
      check("ext_rise_count", tmr0, base + 8'(k + 1));
      t0cki = 1'b0;
      repeat (4) cycle();
      $display("T0CKI rising pulse %0d -> TMR0 %02h", k, tmr0);
    end
`endif

    // Randomized traffic checked every cycle against the model.
    $display("random phase: 3000 cycles");
    for (int n = 0; n < 3000; n++) begin
      rst    = ($urandom_range(0, 499) == 0);
      tmr0_w = ($urandom_range(0, 24) == 0);
      opt_w  = ($urandom_range(0, 39) == 0);
      t0if_c = ($urandom_range(0, 9) == 0);
      wdata  = 8'($urandom);
      if ($urandom_range(0, 29) == 0) sleep = ~sleep;
      if ($urandom_range(0, 2) == 0) t0cki = ~t0cki;
      cycle();
    end
    rst = 1'b0; tmr0_w = 1'b0; opt_w = 1'b0; t0if_c = 1'b0; sleep = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
